// File: rtl/regs_mc.sv
// Multi-channel CSR block: per-channel DATA read FIFO, CTRL, sticky read-to-clear STATUS, START strobe.
// Optional feature: define REGS_MC_WSTRB_EN to honour lb_wstrb on CTRL and START writes.
module regs_mc #(
   parameter int          ADDR_W     = 16,
   parameter int          DATA_W     = 32,
   parameter int          NCH        = 4,
   parameter int          CH_STRIDE  = 'h10,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] CTRL_RESET = 16'h0100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   lb_waddr,
   input  logic [DATA_W-1:0]   lb_wdata,
   input  logic                lb_wen,
   input  logic [DATA_W/8-1:0] lb_wstrb,
   output logic                lb_wready,
   input  logic [ADDR_W-1:0]   lb_raddr,
   input  logic                lb_ren,
   output logic [DATA_W-1:0]   lb_rdata,
   output logic                lb_rvalid,
   input  logic [NCH-1:0]      data_push,
   input  logic [NCH*DATA_W-1:0] data_in,
   input  logic [NCH*6-1:0]    status_set,
   output logic [NCH*16-1:0]   ctrl_out,
   output logic [NCH-1:0]      start_pulse
);

   localparam int SH = $clog2(CH_STRIDE);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [SH-1:0] OFF_DATA   = SH'('h0);
   localparam logic [SH-1:0] OFF_CTRL   = SH'('h4);
   localparam logic [SH-1:0] OFF_STATUS = SH'('h8);
   localparam logic [SH-1:0] OFF_START  = SH'('hC);

   logic [ADDR_W-1:0] w_ch, r_ch;
   logic [SH-1:0]     w_off, r_off;
   logic [1:0]        ctrl_be;
   logic              start_en;
   logic              wstrb_unused, wdata_unused;
   logic [DATA_W-1:0] ch_rword [NCH];
   logic [DATA_W-1:0] rd_val;

   assign w_ch  = lb_waddr >> SH;
   assign w_off = lb_waddr[SH-1:0];
   assign r_ch  = lb_raddr >> SH;
   assign r_off = lb_raddr[SH-1:0];

   assign wstrb_unused = ^lb_wstrb;
   assign wdata_unused = ^lb_wdata[DATA_W-1:16];

`ifdef REGS_MC_WSTRB_EN
   assign ctrl_be  = lb_wstrb[1:0];
   assign start_en = lb_wstrb[0];
`else
   assign ctrl_be  = 2'b11;
   assign start_en = 1'b1;
`endif

   for (genvar g = 0; g < NCH; g++) begin : ch_g
      logic              w_sel, r_sel;
      logic [15:0]       ctrl;
      logic [5:0]        sticky;
      logic              ovf;
      logic              start;
      logic [PW-1:0]     rd_ptr, wr_ptr;
      logic [PW:0]       count;
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic              empty, full, pop, push_ok, overflow, status_rd;
      logic [DATA_W-1:0] rword;

      // Addresses beyond the last channel never match any g, so they fall out as unmapped.
      assign w_sel = (w_ch == ADDR_W'(g));
      assign r_sel = (r_ch == ADDR_W'(g));

      assign empty     = (count == '0);
      assign full      = (count == (PW+1)'(FIFO_DEPTH));
      assign pop       = lb_ren && r_sel && (r_off == OFF_DATA) && !empty;
      assign push_ok   = data_push[g] && (!full || pop);
      assign overflow  = data_push[g] && full && !pop;
      assign status_rd = lb_ren && r_sel && (r_off == OFF_STATUS);

      always_ff @(posedge clk) begin
         if (push_ok) mem[wr_ptr] <= data_in[g*DATA_W +: DATA_W];
      end

      // Set terms are OR-ed in after the read clear so a coincident event survives the clear.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            ctrl   <= CTRL_RESET;
            sticky <= '0;
            ovf    <= 1'b0;
            start  <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: ;
            endcase
            sticky <= (status_rd ? 6'b0 : sticky) | status_set[g*6 +: 6];
            ovf    <= (ovf && !status_rd) || overflow;
            if (lb_wen && w_sel && (w_off == OFF_CTRL)) begin
               if (ctrl_be[0]) ctrl[7:0]  <= lb_wdata[7:0];
               if (ctrl_be[1]) ctrl[15:8] <= lb_wdata[15:8];
            end
            start <= lb_wen && w_sel && (w_off == OFF_START) && lb_wdata[0] && start_en;
         end
      end

      always_comb begin
         rword = '0;
         if (r_sel) begin
            case (r_off)
               OFF_DATA:   if (!empty) rword = mem[rd_ptr];
               OFF_CTRL:   rword = DATA_W'(ctrl);
               OFF_STATUS: rword = DATA_W'({ovf, !empty, sticky});
               default:    ;
            endcase
         end
      end

      assign ch_rword[g]          = rword;
      assign ctrl_out[g*16 +: 16] = ctrl;
      assign start_pulse[g]       = start;
   end

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NCH; i++) rd_val = rd_val | ch_rword[i];
   end

   // Read data is captured only on a read so it holds between accesses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lb_wready <= 1'b0;
         lb_rvalid <= 1'b0;
         lb_rdata  <= '0;
      end else begin
         lb_wready <= lb_wen;
         lb_rvalid <= lb_ren;
         if (lb_ren) lb_rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_regs_mc.sv
// Self-checking bench for regs_mc: vector table, directed corner sequences and a randomized
// run against a queue-based channel model.
module tb_regs_mc;
   localparam int ADDR_W = 16, DATA_W = 32, NCH = 4, DEPTH = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [ADDR_W-1:0]  lb_waddr = '0, lb_raddr = '0;
   logic [DATA_W-1:0]  lb_wdata = '0;
   logic               lb_wen = 1'b0, lb_ren = 1'b0;
   logic [3:0]         lb_wstrb = '0;
   logic               lb_wready, lb_rvalid;
   logic [DATA_W-1:0]  lb_rdata;
   logic [NCH-1:0]     data_push = '0;
   logic [NCH*DATA_W-1:0] data_in = '0;
   logic [NCH*6-1:0]   status_set = '0;
   logic [NCH*16-1:0]  ctrl_out;
   logic [NCH-1:0]     start_pulse;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] CTRL_RST_ALL = 64'h0100_0100_0100_0100;

   regs_mc dut (
      .clk(clk), .rst(rst),
      .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wen(lb_wen), .lb_wstrb(lb_wstrb),
      .lb_wready(lb_wready),
      .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
      .data_push(data_push), .data_in(data_in), .status_set(status_set),
      .ctrl_out(ctrl_out), .start_pulse(start_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_write;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [63:0] exp_ctrl;
   } vec_t;

   vec_t vecs [12];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
      lb_waddr = addr; lb_wdata = data; lb_wstrb = strb; lb_wen = 1'b1;
      tick();
      lb_wen = 1'b0;
      checkOutput($sformatf("wready@%0h", addr), 64'(lb_wready), 64'd1);
   endtask

   task automatic busRead(input logic [15:0] addr, output logic [31:0] d);
      lb_raddr = addr; lb_ren = 1'b1;
      tick();
      lb_ren = 1'b0;
      checkOutput($sformatf("rvalid@%0h", addr), 64'(lb_rvalid), 64'd1);
      d = lb_rdata;
   endtask

   task automatic readExpect(input string name, input logic [15:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      busRead(addr, d);
      checkOutput(name, 64'(d), 64'(exp));
   endtask

   task automatic applyStimulus(input int idx);
      logic [31:0] d;
      if (vecs[idx].is_write) begin
         busWrite(vecs[idx].addr, vecs[idx].wdata, 4'hF);
      end else begin
         busRead(vecs[idx].addr, d);
         checkOutput($sformatf("vec%0d_rdata", idx), 64'(d), 64'(vecs[idx].exp_rdata));
      end
      checkOutput($sformatf("vec%0d_ctrl", idx), ctrl_out, vecs[idx].exp_ctrl);
      checkOutput($sformatf("vec%0d_start", idx), 64'(start_pulse), 64'd0);
   endtask

   // Reference model: one queue per channel FIFO plus plain register copies.
   logic [31:0] mq [NCH][$];
   logic [5:0]  msticky [NCH];
   bit          movf [NCH];
   logic [15:0] mctrl [NCH];

   task automatic runRandom(input int cycles);
      int rch, roff, wch, woff;
      int offs [5] = '{0, 4, 8, 12, 2};
      logic [31:0] exp_rdata, last_rdata;
      logic [NCH-1:0] exp_start;
      logic [63:0] exp_ctrl;
      bit ren, wen, popped, ovf_evt, sread;
      last_rdata = '0;
      for (int c = 0; c < NCH; c++) begin
         mq[c].delete(); msticky[c] = '0; movf[c] = 0; mctrl[c] = 16'h0100;
      end
      for (int n = 0; n < cycles; n++) begin
         ren = 1'($urandom_range(0, 1));
         wen = 1'($urandom_range(0, 2) == 0);
         rch = $urandom_range(0, NCH); roff = offs[$urandom_range(0, 4)];
         wch = $urandom_range(0, NCH); woff = offs[$urandom_range(0, 4)];
         lb_ren = ren; lb_raddr = 16'(rch * 16 + roff);
         lb_wen = wen; lb_waddr = 16'(wch * 16 + woff);
         lb_wdata = $urandom; lb_wstrb = 4'($urandom);
         data_push = 4'($urandom) & 4'($urandom);
         data_in = {$urandom, $urandom, $urandom, $urandom};
         status_set = ($urandom_range(0, 5) == 0) ? 24'($urandom) : '0;

         exp_rdata = '0;
         if (ren && rch < NCH) begin
            case (roff)
               0:  exp_rdata = (mq[rch].size() > 0) ? mq[rch][0] : 32'h0;
               4:  exp_rdata = {16'h0, mctrl[rch]};
               8:  exp_rdata = {24'h0, movf[rch], mq[rch].size() > 0, msticky[rch]};
               default: exp_rdata = '0;
            endcase
         end
         if (ren) last_rdata = exp_rdata;
         exp_start = '0;
`ifdef REGS_MC_WSTRB_EN
         if (wen && wch < NCH && woff == 12 && lb_wdata[0] && lb_wstrb[0]) exp_start[wch] = 1'b1;
`else
         if (wen && wch < NCH && woff == 12 && lb_wdata[0]) exp_start[wch] = 1'b1;
`endif
         for (int c = 0; c < NCH; c++) begin
            popped = ren && rch == c && roff == 0 && mq[c].size() > 0;
            sread  = ren && rch == c && roff == 8;
            if (popped) void'(mq[c].pop_front());
            ovf_evt = 0;
            if (data_push[c]) begin
               if (mq[c].size() < DEPTH) mq[c].push_back(data_in[c*32 +: 32]);
               else ovf_evt = 1;
            end
            if (sread) begin msticky[c] = '0; movf[c] = 0; end
            msticky[c] = msticky[c] | status_set[c*6 +: 6];
            if (ovf_evt) movf[c] = 1;
            if (wen && wch == c && woff == 4) begin
`ifdef REGS_MC_WSTRB_EN
               if (lb_wstrb[0]) mctrl[c][7:0]  = lb_wdata[7:0];
               if (lb_wstrb[1]) mctrl[c][15:8] = lb_wdata[15:8];
`else
               mctrl[c] = lb_wdata[15:0];
`endif
            end
         end
         for (int c = 0; c < NCH; c++) exp_ctrl[c*16 +: 16] = mctrl[c];

         tick();
         checkOutput($sformatf("rnd%0d_rvalid", n), 64'(lb_rvalid), 64'(ren));
         checkOutput($sformatf("rnd%0d_rdata", n), 64'(lb_rdata), 64'(last_rdata));
         checkOutput($sformatf("rnd%0d_wready", n), 64'(lb_wready), 64'(wen));
         checkOutput($sformatf("rnd%0d_start", n), 64'(start_pulse), 64'(exp_start));
         checkOutput($sformatf("rnd%0d_ctrl", n), ctrl_out, exp_ctrl);
      end
      lb_ren = 0; lb_wen = 0; data_push = '0; status_set = '0;
   endtask

   initial begin
      logic [15:0] exp_g;

      vecs[0]  = '{0, 16'h0004, 32'h0, 32'h100, CTRL_RST_ALL};
      vecs[1]  = '{0, 16'h0014, 32'h0, 32'h100, CTRL_RST_ALL};
      vecs[2]  = '{0, 16'h0024, 32'h0, 32'h100, CTRL_RST_ALL};
      vecs[3]  = '{0, 16'h0034, 32'h0, 32'h100, CTRL_RST_ALL};
      vecs[4]  = '{0, 16'h002C, 32'h0, 32'h0, CTRL_RST_ALL};
      vecs[5]  = '{0, 16'h0040, 32'h0, 32'h0, CTRL_RST_ALL};
      vecs[6]  = '{0, 16'h0006, 32'h0, 32'h0, CTRL_RST_ALL};
      vecs[7]  = '{1, 16'h0034, 32'hDEAD5678, 32'h0, 64'h5678_0100_0100_0100};
      vecs[8]  = '{0, 16'h0034, 32'h0, 32'h5678, 64'h5678_0100_0100_0100};
      vecs[9]  = '{1, 16'h0040, 32'hFFFFFFFF, 32'h0, 64'h5678_0100_0100_0100};
      vecs[10] = '{1, 16'h0014, 32'h000000AB, 32'h0, 64'h5678_0100_00AB_0100};
      vecs[11] = '{0, 16'h0008, 32'h0, 32'h0, 64'h5678_0100_00AB_0100};

      // Reset held with requests active: nothing may respond.
      #1 rst = 1'b0;
      lb_ren = 1; lb_raddr = 16'h0004;
      lb_wen = 1; lb_waddr = 16'h000C; lb_wdata = 32'h1; lb_wstrb = 4'hF;
      tick(); tick();
      checkOutput("rst_rvalid", 64'(lb_rvalid), 64'd0);
      checkOutput("rst_wready", 64'(lb_wready), 64'd0);
      checkOutput("rst_start", 64'(start_pulse), 64'd0);
      checkOutput("rst_rdata", 64'(lb_rdata), 64'd0);
      checkOutput("rst_ctrl", ctrl_out, CTRL_RST_ALL);
      lb_ren = 0; lb_wen = 0;
      rst = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) applyStimulus(i);

      // START on ch2: one-cycle pulse at T+1.
      busWrite(16'h002C, 32'h1, 4'hF);
      checkOutput("start_ch2", 64'(start_pulse), 64'b0100);
      tick();
      checkOutput("start_ch2_off", 64'(start_pulse), 64'd0);
      checkOutput("wready_off", 64'(lb_wready), 64'd0);
      readExpect("start_rd0", 16'h002C, 32'h0);
      busWrite(16'h002C, 32'h0, 4'hF);
      checkOutput("start_zero", 64'(start_pulse), 64'd0);

      // Byte-strobed CTRL write and strobed START on ch0.
`ifdef REGS_MC_WSTRB_EN
      exp_g = 16'hBE00;
`else
      exp_g = 16'hBEEF;
`endif
      busWrite(16'h0004, 32'h0000BEEF, 4'b0010);
      checkOutput("wstrb_ctrl", 64'(ctrl_out[15:0]), 64'(exp_g));
      busWrite(16'h000C, 32'h1, 4'b1110);
`ifdef REGS_MC_WSTRB_EN
      checkOutput("wstrb_start", 64'(start_pulse), 64'd0);
`else
      checkOutput("wstrb_start", 64'(start_pulse), 64'b0001);
`endif

      // Same-cycle read and write of CTRL returns the pre-write value.
      lb_raddr = 16'h0004; lb_ren = 1;
      lb_waddr = 16'h0004; lb_wdata = 32'h1234; lb_wstrb = 4'hF; lb_wen = 1;
      tick();
      lb_ren = 0; lb_wen = 0;
      checkOutput("rw_same_rdata", 64'(lb_rdata), 64'(exp_g));
      checkOutput("rw_same_ctrl", 64'(ctrl_out[15:0]), 64'h1234);
      readExpect("rw_after", 16'h0004, 32'h1234);

      // Overfill ch1, then drain back-to-back.
      for (int i = 0; i < 5; i++) begin
         data_push = 4'b0010; data_in[32 +: 32] = 32'hA0 + 32'(i);
         tick();
      end
      data_push = '0;
      lb_raddr = 16'h0010; lb_ren = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput($sformatf("drain%0d", i), 64'(lb_rdata), (i < 4) ? 64'(32'hA0 + 32'(i)) : 64'd0);
      end
      lb_ren = 0;
      readExpect("ovf_status", 16'h0018, 32'h80);
      readExpect("ovf_cleared", 16'h0018, 32'h00);

      // Sticky STATUS with a set coinciding with the clearing read.
      status_set = 24'h8; tick(); status_set = '0;
      readExpect("sticky_set", 16'h0008, 32'h08);
      readExpect("sticky_clr", 16'h0008, 32'h00);
      lb_raddr = 16'h0008; lb_ren = 1; status_set = 24'h8;
      tick();
      lb_ren = 0; status_set = '0;
      checkOutput("sticky_race_rd", 64'(lb_rdata), 64'h0);
      readExpect("sticky_race_after", 16'h0008, 32'h08);

      // Push into a full FIFO while it is being popped: accepted, no overflow.
      for (int i = 0; i < 4; i++) begin
         data_push = 4'b0100; data_in[64 +: 32] = 32'hC0 + 32'(i);
         tick();
      end
      lb_raddr = 16'h0020; lb_ren = 1; data_in[64 +: 32] = 32'hC4;
      tick();
      lb_ren = 0; data_push = '0;
      checkOutput("fullpop_rd", 64'(lb_rdata), 64'hC0);
      readExpect("fullpop_status", 16'h0028, 32'h40);
      for (int i = 1; i < 5; i++) readExpect($sformatf("fullpop_drain%0d", i), 16'h0020, 32'hC0 + 32'(i));
      readExpect("fullpop_status2", 16'h0028, 32'h00);

      // Unmapped channel read and write in the same cycle.
      lb_raddr = 16'h0040; lb_ren = 1;
      lb_waddr = 16'h0040; lb_wdata = 32'hFFFF_FFFF; lb_wstrb = 4'hF; lb_wen = 1;
      tick();
      lb_ren = 0; lb_wen = 0;
      checkOutput("unmap_rvalid", 64'(lb_rvalid), 64'd1);
      checkOutput("unmap_wready", 64'(lb_wready), 64'd1);
      checkOutput("unmap_rdata", 64'(lb_rdata), 64'd0);
      checkOutput("unmap_start", 64'(start_pulse), 64'd0);
      checkOutput("unmap_ctrl", ctrl_out, 64'h5678_0100_00AB_1234);

      // Reset mid-transaction discards the request and FIFO contents.
      data_push = 4'b1000; data_in[96 +: 32] = 32'h5555; tick(); data_push = '0;
      lb_raddr = 16'h0030; lb_ren = 1;
      lb_waddr = 16'h003C; lb_wdata = 32'h1; lb_wen = 1;
      #2 rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_rvalid", 64'(lb_rvalid), 64'd0);
      checkOutput("midrst_wready", 64'(lb_wready), 64'd0);
      checkOutput("midrst_start", 64'(start_pulse), 64'd0);
      checkOutput("midrst_ctrl", ctrl_out, CTRL_RST_ALL);
      lb_ren = 0; lb_wen = 0;
      #1 rst = 1'b1;
      tick();
      readExpect("midrst_status", 16'h0038, 32'h0);
      readExpect("midrst_data", 16'h0030, 32'h0);

      // Fresh reset before the randomized run so the model starts from reset state.
      rst = 1'b0; tick(); rst = 1'b1; tick();
      runRandom(600);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
